tof_stim_gen: RTL and testbench

Programmable two-channel edge generator: the transmit end of the delay-estimator measurement path. It produces a square wave on X1 and a copy on X2 delayed by a programmed number of clock cycles. These signals feed the synchronizer/TOF-counter input of the estimator, both on silicon test setups and in closed-loop benches. Delay, half-period and frame count are loaded by a host, and runs are started and stopped with single-cycle pulses.

---
 rtl/tof_stim_gen_pkg.sv | 16 +
 rtl/tof_phase_cnt.sv | 49 ++++
 rtl/tof_stim_gen.sv | 184 ++++++++++++++++++
 tb/tb_tof_stim_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tof_stim_gen_pkg.sv
// Shared constants for the TOF stimulus generator: FSM encodings,
// default field widths and the power-up configuration.
package tof_stim_gen_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_FW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    localparam int H_RST = 1;
    localparam int D_RST = 0;
    localparam int F_RST = 1;

endpackage

// File: rtl/tof_phase_cnt.sv
// Loadable modulo-2H phase counter. Reports when it sits on its last
// phase (2H-1) and whether its next value lies in the high half (< H),
// so the parent can register square-wave outputs without extra latency.
module tof_phase_cnt
    import tof_stim_gen_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic [W-1:0] half,
    input  logic         load,
    input  logic [W:0]   load_val,
    input  logic         en,
    output logic         at_top,
    output logic         high_next
);

    localparam logic [W:0] ONE = (W+1)'(1);

    logic [W:0] count;
    logic [W:0] count_next;
    logic [W:0] top_val;

    assign top_val = {half, 1'b0} - ONE;
    assign at_top  = (count == top_val);

    // Next phase: a load wins, otherwise step and wrap after 2H-1
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = at_top ? '0 : count + ONE;
        end
    end

    assign high_next = (count_next < {1'b0, half});

    // Phase register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/tof_stim_gen.sv
// Two-channel edge generator: X1 is a square wave of half-period H and X2
// is the same wave delayed by D cycles. Runs last F frames (0 = forever),
// followed by a D-cycle tail that flushes the delayed copy of the last frame.
module tof_stim_gen
    import tof_stim_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int FW = DEF_FW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          load,
    input  logic [W-1:0]  H_in,
    input  logic [W:0]    D_in,
    input  logic [FW-1:0] frames_in,
    input  logic          start,
    input  logic          stop,
    output logic          X1,
    output logic          X2,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [W:0]    ONE_D = (W+1)'(1);
    localparam logic [FW-1:0] ONE_F = FW'(1);

    logic [1:0]    state;
    logic [W-1:0]  h_reg;
    logic [W:0]    d_reg;
    logic [FW-1:0] f_reg;
    logic [FW-1:0] tally;
    logic [W:0]    prime;
    logic          x1_q;
    logic          x2_q;
    logic          busy_q;
    logic          done_q;
    logic          cfg_err_q;

    logic [W:0]    two_h;
    logic [W:0]    ph2_init;
    logic [FW-1:0] tally_inc;
    logic          cfg_valid;
    logic          take_start;
    logic          take_load;
    logic          last_frame;
    logic          primed_next;
    logic          cnt_en;
    logic          ph2_en;
    logic          cnt_top;
    logic          cnt_hi_next;
    logic          ph2_top;
    logic          ph2_hi_next;

    assign two_h       = {h_reg, 1'b0};
    assign cfg_valid   = (h_reg != '0) && (d_reg < two_h);
    assign ph2_init    = (d_reg == '0) ? '0 : two_h - d_reg;
    assign take_start  = (state == ST_IDLE) && start && !stop && cfg_valid;
    assign take_load   = (state == ST_IDLE) && load && !take_start;
    assign tally_inc   = tally + ONE_F;
    assign last_frame  = cnt_top && (f_reg != '0) && (tally_inc == f_reg);
    assign primed_next = (prime == d_reg) || ((prime + ONE_D) == d_reg);
    assign cnt_en      = (state == ST_RUN);
    assign ph2_en      = (state == ST_RUN) || (state == ST_TAIL);

    tof_phase_cnt #(.W(W)) u_cnt (
        .clk       (clk),
        .reset_L   (reset_L),
        .half      (h_reg),
        .load      (take_start),
        .load_val  ('0),
        .en        (cnt_en),
        .at_top    (cnt_top),
        .high_next (cnt_hi_next)
    );

    tof_phase_cnt #(.W(W)) u_ph2 (
        .clk       (clk),
        .reset_L   (reset_L),
        .half      (h_reg),
        .load      (take_start),
        .load_val  (ph2_init),
        .en        (ph2_en),
        .at_top    (ph2_top),
        .high_next (ph2_hi_next)
    );

    // Host config registers, writable only while idle and not starting
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            h_reg <= W'(H_RST);
            d_reg <= (W+1)'(D_RST);
            f_reg <= FW'(F_RST);
        end else if (take_load) begin
            h_reg <= H_in;
            d_reg <= D_in;
            f_reg <= frames_in;
        end
    end

    // Run FSM with registered outputs computed from the counters' next phase
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state     <= ST_IDLE;
            tally     <= '0;
            prime     <= '0;
            x1_q      <= 1'b0;
            x2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (stop) begin
                state  <= ST_IDLE;
                x1_q   <= 1'b0;
                x2_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (take_start) begin
                            state  <= ST_RUN;
                            tally  <= '0;
                            prime  <= '0;
                            x1_q   <= cnt_hi_next;
                            x2_q   <= (d_reg == '0) && ph2_hi_next;
                            busy_q <= 1'b1;
                        end else if (start) begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (last_frame) begin
                            x1_q <= 1'b0;
                            if (d_reg == '0) begin
                                state  <= ST_IDLE;
                                x2_q   <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_TAIL;
                                x2_q  <= ph2_hi_next;
                            end
                        end else begin
                            if (cnt_top) begin
                                tally <= tally_inc;
                            end
                            if (prime != d_reg) begin
                                prime <= prime + ONE_D;
                            end
                            x1_q <= cnt_hi_next;
                            x2_q <= primed_next && ph2_hi_next;
                        end
                    end
                    ST_TAIL: begin
                        if (ph2_top) begin
                            state  <= ST_IDLE;
                            x2_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            x2_q <= ph2_hi_next;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        x1_q   <= 1'b0;
                        x2_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign X1      = x1_q;
    assign X2      = x2_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tof_stim_gen.sv
// Bench for tof_stim_gen: directed cases plus randomized runs checked
// against a closed-form model of the X1/X2 waveforms.
module tb_tof_stim_gen;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       load;
    logic       start;
    logic       stop;
    logic [7:0] H_in;
    logic [8:0] D_in;
    logic [7:0] frames_in;
    logic       X1;
    logic       X2;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int total = 0;
    int bad   = 0;
    int cfg_h;
    int cfg_d;
    int cfg_f;

    tof_stim_gen #(.W(8), .FW(8)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (load),
        .H_in      (H_in),
        .D_in      (D_in),
        .frames_in (frames_in),
        .start     (start),
        .stop      (stop),
        .X1        (X1),
        .X2        (X2),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference X1 level k cycles into a run (negative k = before start)
    function automatic bit model_x1(input int k, input int h, input int f);
        if (k < 0) return 1'b0;
        if (f != 0 && k >= 2 * h * f) return 1'b0;
        return (k % (2 * h)) < h;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_x1"}, X1, 0);
        checkOutput({tag, "_x2"}, X2, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_cfgerr"}, cfg_err, 0);
    endtask

    // Load a configuration while idle; it is usable on the next cycle
    task automatic applyStimulus(input int h, input int d, input int f);
        H_in      = 8'(h);
        D_in      = 9'(d);
        frames_in = 8'(f);
        load      = 1'b1;
        step();
        load      = 1'b0;
        cfg_h     = h;
        cfg_d     = d;
        cfg_f     = f;
    endtask

    // Start a run with the current config and check every cycle of it
    task automatic startRun(input int stop_k, input bit noise);
        int end_k;
        int last;
        bit valid;
        start = 1'b1;
        step();
        start = 1'b0;
        valid = (cfg_h != 0) && (cfg_d < 2 * cfg_h);
        if (!valid) begin
            checkOutput("rej_cfgerr", cfg_err, 1);
            checkOutput("rej_busy", busy, 0);
            checkOutput("rej_x1", X1, 0);
            checkOutput("rej_x2", X2, 0);
            step();
            checkIdle("rej_after");
            return;
        end
        end_k = (cfg_f == 0) ? -1 : 2 * cfg_h * cfg_f + cfg_d;
        last  = (stop_k >= 0) ? stop_k + 2 : end_k + 1;
        for (int k = 0; k <= last; k++) begin
            bit live;
            bit ex1;
            bit ex2;
            bit eb;
            bit ed;
            live = (stop_k < 0) || (k <= stop_k);
            ex1 = 1'b0;
            ex2 = 1'b0;
            eb  = 1'b0;
            ed  = 1'b0;
            if (live) begin
                ex1 = model_x1(k, cfg_h, cfg_f);
                ex2 = model_x1(k - cfg_d, cfg_h, cfg_f);
                eb  = (end_k < 0) || (k < end_k);
                ed  = (k == end_k);
            end
            checkOutput("run_x1", X1, ex1);
            checkOutput("run_x2", X2, ex2);
            checkOutput("run_busy", busy, eb);
            checkOutput("run_done", done, ed);
            checkOutput("run_cfgerr", cfg_err, 0);
            if (k == stop_k) stop = 1'b1;
            if (noise && live && (end_k < 0 || k < end_k)) begin
                if ($urandom_range(0, 3) == 0) begin
                    load      = 1'b1;
                    H_in      = 8'd7;
                    D_in      = 9'($urandom_range(0, 13));
                    frames_in = 8'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 5) == 0) start = 1'b1;
            end
            step();
            load  = 1'b0;
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    // Test sequence
    initial begin
        reset_L   = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        H_in      = '0;
        D_in      = '0;
        frames_in = '0;
        repeat (3) step();
        checkIdle("reset");
        reset_L = 1'b1;
        step();

        // D below H, two frames, then D above H
        applyStimulus(4, 3, 2);
        startRun(-1, 1'b0);
        applyStimulus(4, 6, 2);
        startRun(-1, 1'b0);

        // Zero delay continuous, stopped at cycle 10
        applyStimulus(3, 0, 0);
        startRun(9, 1'b0);

        // Loads and starts during a run must be ignored
        applyStimulus(4, 5, 3);
        startRun(-1, 1'b1);

        // Rejected configurations
        applyStimulus(0, 0, 1);
        startRun(-1, 1'b0);
        applyStimulus(4, 8, 1);
        startRun(-1, 1'b0);

        // stop beats start in the same idle cycle
        applyStimulus(2, 1, 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checkIdle("stopstart");
        step();
        checkIdle("stopstart2");

        // Reset in the middle of a continuous run restores the defaults
        applyStimulus(4, 3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        checkOutput("rst_busy_pre", busy, 1);
        reset_L = 1'b0;
        step();
        checkOutput("rst_x1", X1, 0);
        checkOutput("rst_x2", X2, 0);
        checkOutput("rst_busy", busy, 0);
        step();
        reset_L = 1'b1;
        cfg_h = 1;
        cfg_d = 0;
        cfg_f = 1;
        startRun(-1, 1'b0);

        // Randomized runs
        for (int n = 0; n < 25; n++) begin
            int h;
            int d;
            int f;
            int sk;
            int e;
            h = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) d = $urandom_range(2 * h, 2 * h + 2);
            else d = $urandom_range(0, 2 * h - 1);
            if ($urandom_range(0, 11) == 0) h = 0;
            f  = $urandom_range(0, 3);
            sk = -1;
            if (h != 0 && d < 2 * h) begin
                e = 2 * h * f + d;
                if (f == 0) sk = $urandom_range(0, 40);
                else if ($urandom_range(0, 3) == 0) sk = $urandom_range(0, e - 1);
            end
            applyStimulus(h, d, f);
            startRun(sk, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
